// File: rtl/op_cmd_assembler.sv
// Assembles 16-bit ops from pairs of UART bytes (high byte first) and queues
// them in a first-word-fall-through FIFO, with a timeout on half-received ops.
module op_cmd_assembler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  UART_Rx_DATA,
  input  logic        UART_Rx_valid,
  input  logic        op_stack_pull,
  output logic [15:0] op_stack_msg,
  output logic        op_stack_empty,
  output logic        op_stack_full,
  output logic        cmd_drop,
  output logic        cmd_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [7:0]      hi_byte;
  logic [TW-1:0]   to_cnt;
  logic            push;
  logic            timeout_evt;

  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pull;
  logic            drop_evt;

  // Inputs are masked while reset is held so nothing reaches the FIFO or FSM.
  logic            valid_in;
  logic            pull_in;

  assign valid_in = UART_Rx_valid & rst;
  assign pull_in  = op_stack_pull & rst;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    push        = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      WAIT_HI: begin
        if (valid_in) next_state = WAIT_LO;
      end
      WAIT_LO: begin
        if (valid_in) begin
          push       = 1'b1;
          next_state = WAIT_HI;
        end else if (to_cnt == TO_LAST) begin
          timeout_evt = 1'b1;
          next_state  = WAIT_HI;
        end
      end
      default: next_state = WAIT_HI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= WAIT_HI;
    end else begin
      state <= next_state;
    end
  end

  // The counter holds at TO_LAST instead of wrapping; the FSM leaves WAIT_LO there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_byte <= 8'h00;
      to_cnt  <= '0;
    end else if (state == WAIT_HI) begin
      if (valid_in) begin
        hi_byte <= UART_Rx_DATA;
        to_cnt  <= '0;
      end
    end else if (!valid_in && (to_cnt != TO_LAST)) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // A pull on a full FIFO frees the slot the coincident push needs.
  assign do_pull  = pull_in && !op_stack_empty;
  assign do_push  = push && (!op_stack_full || do_pull);
  assign drop_evt = push && op_stack_full && !do_pull;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pull) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pull})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // count and the output is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {hi_byte, UART_Rx_DATA};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_drop    <= 1'b0;
      cmd_timeout <= 1'b0;
    end else begin
      cmd_drop    <= drop_evt;
      cmd_timeout <= timeout_evt;
    end
  end

  assign op_stack_empty = (count == '0);
  assign op_stack_full  = (count == COUNT_FULL);
  assign op_stack_msg   = op_stack_empty ? 16'h0000 : mem[rd_ptr];

endmodule
